object_slot_unit: RTL and testbench

Allocates, tracks and releases the 32 object slots of video memory. It sits between the CPU-facing matrix unit and the video memory unit. On a create request it finds a free slot with a next-fit sequential scan and returns the slot address on a one-cycle `addr_vld` strobe. The matrix unit uses that strobe to write the object record. The block also services delete, delete-all and address-reference requests, and reports the last stored object and a memory-full flag.

---
 rtl/object_slot_unit_if.sv | 36 +++
 rtl/object_slot_unit.sv | 160 ++++++++++++++++
 tb/tb_object_slot_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/object_slot_unit_if.sv
// Request/response bundle between the matrix unit and the object slot allocator.
interface object_slot_unit_if #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_OBJ = 32
);

  // Requests from the matrix unit
  logic               crt_obj;
  logic               del_obj;
  logic               del_all;
  logic               ref_addr;
  logic [ADDR_W-1:0]  obj_num_in;

  // Responses and status from the slot unit
  logic               busy;
  logic               addr_vld;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  lst_stored_obj;
  logic               lst_stored_obj_vld;
  logic               obj_mem_full;
  logic [NUM_OBJ-1:0] valid_mask;
  logic               err;

  modport master (
    output crt_obj, del_obj, del_all, ref_addr, obj_num_in,
    input  busy, addr_vld, addr, lst_stored_obj, lst_stored_obj_vld,
           obj_mem_full, valid_mask, err
  );

  modport slave (
    input  crt_obj, del_obj, del_all, ref_addr, obj_num_in,
    output busy, addr_vld, addr, lst_stored_obj, lst_stored_obj_vld,
           obj_mem_full, valid_mask, err
  );

endinterface

// File: rtl/object_slot_unit.sv
// Object slot allocator: next-fit create, delete, delete-all and reference.
module object_slot_unit #(
  parameter int unsigned NUM_OBJ = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input logic               clk,
  input logic               rst_n,
  object_slot_unit_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

  state_t             state_q, state_d;

  logic [NUM_OBJ-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  nf_q, nf_d;
  logic [ADDR_W-1:0]  scan_q, scan_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               addr_vld_q, addr_vld_d;
  logic [ADDR_W-1:0]  lst_q, lst_d;
  logic               lst_vld_q, lst_vld_d;
  logic               err_q, err_d;
  logic               full_q, full_d;

  logic               slot_live;
  logic               scan_live;

  assign slot_live = mask_q[bus.obj_num_in];
  assign scan_live = mask_q[scan_q];
  assign full_d    = (cnt_d == CNT_W'(NUM_OBJ));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only an accepted create enters SEARCH; a free slot ends it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.del_obj && bus.crt_obj && !full_q) begin
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (!scan_live) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Output and datapath next values; strobes default low every cycle
  always_comb begin
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    nf_d       = nf_q;
    scan_d     = scan_q;
    addr_d     = addr_q;
    addr_vld_d = 1'b0;
    lst_d      = lst_q;
    lst_vld_d  = lst_vld_q;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.del_obj) begin
          if (bus.del_all) begin
            mask_d    = '0;
            cnt_d     = '0;
            nf_d      = '0;
            lst_vld_d = 1'b0;
          end else if (slot_live) begin
            mask_d[bus.obj_num_in] = 1'b0;
            cnt_d                  = cnt_q - CNT_W'(1);
            if (bus.obj_num_in == lst_q) begin
              lst_vld_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.crt_obj) begin
          if (full_q) begin
            err_d = 1'b1;
          end else begin
            scan_d = nf_q;
          end
        end else if (bus.ref_addr) begin
          if (slot_live) begin
            addr_d     = bus.obj_num_in;
            addr_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEARCH: begin
        if (scan_live) begin
          scan_d = scan_q + ADDR_W'(1);
        end else begin
          mask_d[scan_q] = 1'b1;
          cnt_d          = cnt_q + CNT_W'(1);
          addr_d         = scan_q;
          addr_vld_d     = 1'b1;
          lst_d          = scan_q;
          lst_vld_d      = 1'b1;
          nf_d           = scan_q + ADDR_W'(1);
        end
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      cnt_q      <= '0;
      nf_q       <= '0;
      scan_q     <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      lst_q      <= '0;
      lst_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      nf_q       <= nf_d;
      scan_q     <= scan_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      lst_q      <= lst_d;
      lst_vld_q  <= lst_vld_d;
      err_q      <= err_d;
      full_q     <= full_d;
    end
  end

  assign bus.busy               = (state_q == ST_SEARCH);
  assign bus.addr_vld           = addr_vld_q;
  assign bus.addr               = addr_q;
  assign bus.lst_stored_obj     = lst_q;
  assign bus.lst_stored_obj_vld = lst_vld_q;
  assign bus.obj_mem_full       = full_q;
  assign bus.valid_mask         = mask_q;
  assign bus.err                = err_q;

endmodule

// File: tb/tb_object_slot_unit.sv
// Scoreboard bench for object_slot_unit: directed requests, decoupled strobe monitor.
module tb_object_slot_unit;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_OBJ = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  object_slot_unit_if #(.ADDR_W(ADDR_W), .NUM_OBJ(NUM_OBJ)) bus ();

  object_slot_unit #(.NUM_OBJ(NUM_OBJ), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit                is_err;
    logic [ADDR_W-1:0] a;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state of the slot table
  logic [NUM_OBJ-1:0] m_mask;
  int                 m_cnt;
  logic [ADDR_W-1:0]  m_lst;
  logic               m_lst_vld;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe monitor: every addr_vld/err must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (bus.addr_vld === 1'b1 || bus.err === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: addr_vld=%0b err=%0b addr=%0d (cycle %0d)",
                   bus.addr_vld, bus.err, bus.addr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_err", 32'(bus.err), 32'(mon_e.is_err));
          check("strobe_addr_vld", 32'(bus.addr_vld), 32'(!mon_e.is_err));
          check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
          if (!mon_e.is_err) check("strobe_addr", 32'(bus.addr), 32'(mon_e.a));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.crt_obj    = 1'b0;
    bus.del_obj    = 1'b0;
    bus.del_all    = 1'b0;
    bus.ref_addr   = 1'b0;
    bus.obj_num_in = '0;
  endtask

  task automatic model_reset();
    m_mask    = '0;
    m_cnt     = 0;
    m_lst     = '0;
    m_lst_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    check("idle_wait", 32'(bus.busy), 32'd0);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.a      = '0;
    e.cyc    = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Create expected to allocate exp_addr with addr_vld lat cycles after the request
  task automatic do_create(input int exp_addr, input int lat);
    exp_t e;
    e.is_err = 1'b0;
    e.a      = ADDR_W'(exp_addr);
    e.cyc    = cyc + lat;
    exp_q.push_back(e);
    m_mask[exp_addr] = 1'b1;
    m_cnt++;
    m_lst     = ADDR_W'(exp_addr);
    m_lst_vld = 1'b1;
    bus.crt_obj = 1'b1;
    step();
    idle_inputs();
    wait_idle();
  endtask

  task automatic do_create_full();
    push_err();
    bus.crt_obj = 1'b1;
    step();
    idle_inputs();
    check("busy_after_full_create", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_del(input int obj, input bit exp_err);
    if (exp_err) begin
      push_err();
    end else begin
      m_mask[obj] = 1'b0;
      m_cnt--;
      if (ADDR_W'(obj) == m_lst) m_lst_vld = 1'b0;
    end
    bus.del_obj    = 1'b1;
    bus.obj_num_in = ADDR_W'(obj);
    step();
    idle_inputs();
  endtask

  task automatic do_del_all();
    m_mask    = '0;
    m_cnt     = 0;
    m_lst_vld = 1'b0;
    bus.del_obj = 1'b1;
    bus.del_all = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic do_ref(input int obj, input bit exp_err);
    exp_t e;
    if (exp_err) begin
      push_err();
    end else begin
      e.is_err = 1'b0;
      e.a      = ADDR_W'(obj);
      e.cyc    = cyc + 1;
      exp_q.push_back(e);
    end
    bus.ref_addr   = 1'b1;
    bus.obj_num_in = ADDR_W'(obj);
    step();
    idle_inputs();
  endtask

  task automatic check_state();
    check("valid_mask", bus.valid_mask, m_mask);
    check("obj_mem_full", 32'(bus.obj_mem_full), 32'(m_cnt == NUM_OBJ));
    check("lst_stored_obj_vld", 32'(bus.lst_stored_obj_vld), 32'(m_lst_vld));
    if (m_lst_vld) check("lst_stored_obj", 32'(bus.lst_stored_obj), 32'(m_lst));
  endtask

  task automatic check_reset();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr_vld", 32'(bus.addr_vld), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_lst_stored_obj", 32'(bus.lst_stored_obj), 32'd0);
    check("rst_lst_vld", 32'(bus.lst_stored_obj_vld), 32'd0);
    check("rst_full", 32'(bus.obj_mem_full), 32'd0);
    check("rst_mask", bus.valid_mask, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First create after reset lands in slot 0
    do_create(0, 2);
    check("first_lst", 32'(bus.lst_stored_obj), 32'd0);
    check("first_mask", bus.valid_mask, 32'h0000_0001);
    check_state();

    // Fill the remaining slots back to back
    for (int i = 1; i < 32; i++) do_create(i, 2);
    check("full_flag", 32'(bus.obj_mem_full), 32'd1);
    check("full_mask", bus.valid_mask, 32'hFFFF_FFFF);

    // Create on a full table is rejected
    do_create_full();
    check("full_mask_unchanged", bus.valid_mask, 32'hFFFF_FFFF);
    step();

    // Free 5 and 6; next-fit pointer wrapped to 0 so five live slots are skipped
    do_del(5, 1'b0);
    do_del(6, 1'b0);
    check_state();
    do_create(5, 7);
    do_create(6, 2);
    check_state();

    // Reference on live and freed slots, delete of a free slot
    do_ref(3, 1'b0);
    do_del(3, 1'b0);
    check_state();
    do_ref(3, 1'b1);
    do_del(3, 1'b1);
    step();
    check_state();

    // Delete-all, then ten live slots, then delete-all again
    do_del_all();
    check_state();
    for (int i = 0; i < 10; i++) do_create(i, 2);
    check("ten_mask", bus.valid_mask, 32'h0000_03FF);
    do_del_all();
    check("delall_mask", bus.valid_mask, 32'd0);
    check("delall_full", 32'(bus.obj_mem_full), 32'd0);
    check("delall_lst_vld", 32'(bus.lst_stored_obj_vld), 32'd0);
    do_create(0, 2);
    do_create(1, 2);
    do_create(2, 2);
    check_state();

    // Delete and create together: only the delete runs (slot 2 was the last stored)
    m_mask[2] = 1'b0;
    m_cnt--;
    m_lst_vld = 1'b0;
    bus.del_obj    = 1'b1;
    bus.crt_obj    = 1'b1;
    bus.obj_num_in = 5'd2;
    step();
    idle_inputs();
    check("simul_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    check("simul_busy_later", 32'(bus.busy), 32'd0);
    check_state();

    // Reset during a long search: table full except slot 20, pointer at 0
    do_del_all();
    for (int i = 0; i < 32; i++) do_create(i, 2);
    do_del(20, 1'b0);
    bus.crt_obj = 1'b1;
    step();
    idle_inputs();
    repeat (10) step();
    check("search_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset();
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_reset();
    do_create(0, 2);
    check_state();

    repeat (5) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
